vram_write_router: RTL
======================

Name: vram_write_router

Overview:
- Parametrised successor to the fixed five-way graphics memory decoder.
- Takes Avalon-MM slave writes from the HPS bridge and decodes them against NUM_REGIONS programmable base/size windows (tile buffer, tile graphics, sprite graphics, palettes, OAM).
- Issues one registered write strobe per cycle with a region-relative offset.
- Writes to regions flagged in DEFER_MASK are queued in a FIFO and drained only while vblank is high, so palette and OAM updates never tear mid-frame.

Parameters:
- ADDR_W, 12, host word-address width; also the width of the offset output.
- DATA_W, 32, write data width.
- NUM_REGIONS, 5, number of decode windows.
- REGION_BASE, {12'hE00,12'hC00,12'h800,12'h400,12'h000}, packed NUM_REGIONS*ADDR_W base addresses; region i occupies slice i.
- REGION_SIZE, {12'h200,12'h200,12'h400,12'h400,12'h400}, packed window sizes in words.
- DEFER_MASK, 5'b11000, bit i=1 means region i writes are held until vblank.
- FIFO_DEPTH, 8, deferred-write queue depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- chip_select  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- address  in  ADDR_W  Avalon word address.
- writedata  in  DATA_W  Avalon write data.
- waitrequest  out  1  Avalon stall (combinational).
- vblank  in  1  high during the vertical blanking interval; synchronous to clk.
- mem_we  out  NUM_REGIONS  one-hot write enable per region.
- mem_addr  out  ADDR_W  offset within the selected region (address minus REGION_BASE).
- mem_wdata  out  DATA_W  write data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current deferred-queue occupancy.
- miss_count  out  16  count of writes matching no region; saturating.

Behaviour:
- Reset (async assert, sync release): mem_we=0, mem_addr=0, mem_wdata=0, fifo_level=0, miss_count=0; FIFO emptied. Reset mid-drain discards all queued entries.
- Accepted write: chip_select & write & !waitrequest.
- Decode: region i matches when REGION_BASE[i] <= address < REGION_BASE[i]+REGION_SIZE[i]. The lowest matching index wins on overlap.
- No match: nothing is issued, and miss_count increments, saturating at 16'hFFFF.
- Direct region (DEFER_MASK[i]=0): on the cycle after acceptance, mem_we[i]=1 for exactly one cycle, with mem_addr=offset and mem_wdata=writedata. Latency is 1 cycle.
- Deferred region: the entry {region index, offset, data} is pushed into the FIFO. This applies even when vblank is high and the FIFO is empty, so ordering is always via the queue.
- Drain: when vblank=1, FIFO is non-empty and no direct write is being issued next cycle, pop the head. It appears on the mem_* outputs the following cycle, giving a maximum drain rate of 1 entry per cycle.
- Collision: a direct write has priority for the output port; the drain pops nothing that cycle.
- vblank falling: no pop on any cycle where vblank=0. An entry popped on the last vblank cycle still issues the next cycle.
- Full FIFO: waitrequest=1 whenever chip_select & write targets a deferred region and fifo_level==FIFO_DEPTH. A pop in the same cycle does not lift waitrequest. waitrequest=0 for all other accesses.
- Push and pop in the same cycle: allowed when not full; fifo_level is unchanged.
- Outputs: mem_we is one-hot or zero, never multi-hot. mem_addr and mem_wdata hold their last value when mem_we=0.
- Reads: the block is write-only. A read (chip_select & !write) is ignored with waitrequest=0.

Test Plan:
- Direct write: reset; write addr 12'h405, data 32'hDEADBEEF -> next cycle mem_we=5'b00010, mem_addr=12'h005, mem_wdata=32'hDEADBEEF; all mem_we zero the cycle after.
- Deferred hold: vblank=0; write 12'hC03 with 32'h00FF00FF, then 12'hE10 with 32'h1 -> no mem_we, fifo_level=2. Raise vblank -> mem_we=5'b01000/offset 3, then 5'b10000/offset 16 on consecutive cycles; fifo_level returns to 0.
- Full/backpressure: vblank=0; issue 9 writes to 12'hC00..C08 -> waitrequest rises on the 9th, fifo_level=8. Raise vblank -> the 9th write is accepted once the FIFO is no longer full, and all 9 drain in order.
- Collision: vblank=1 with 3 queued entries; direct write to 12'h010 -> the direct write issues at 1-cycle latency, the drain pauses that cycle, and the remaining entries follow in order.
- vblank drop and reset: 4 entries queued, vblank high for 2 cycles -> exactly 2 drained, fifo_level=2. Assert reset_n=0 -> fifo_level=0 and mem_we=0 immediately.
- Miss: reconfigure REGION_SIZE[4]=12'h100 and write 12'hF00 -> no mem_we, miss_count=1. Force miss_count to 16'hFFFF, then miss again -> miss_count stays 16'hFFFF.

Source files
------------

// File: rtl/vram_write_router.sv
// Decodes host writes into NUM_REGIONS VRAM windows; writes to deferred
// windows are queued and only drained while vblank is high.
module vram_write_router #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int NUM_REGIONS = 5,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {12'hE00, 12'hC00, 12'h800, 12'h400, 12'h000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE =
        {12'h200, 12'h200, 12'h400, 12'h400, 12'h400},
    parameter logic [NUM_REGIONS-1:0] DEFER_MASK = 5'b11000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          chip_select,
    input  logic                          write,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             writedata,
    output logic                          waitrequest,
    input  logic                          vblank,
    output logic [NUM_REGIONS-1:0]        mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   miss_count
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + ADDR_W + DATA_W;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [ADDR_W-1:0] hit_off;
    logic [ADDR_W:0]   win_lo;
    logic [ADDR_W:0]   win_hi;

    // Walk downwards so the lowest matching index is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_off = '0;
        win_lo  = '0;
        win_hi  = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            win_lo = {1'b0, REGION_BASE[i*ADDR_W +: ADDR_W]};
            win_hi = win_lo + {1'b0, REGION_SIZE[i*ADDR_W +: ADDR_W]};
            if ({1'b0, address} >= win_lo && {1'b0, address} < win_hi) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                hit_off = address - win_lo[ADDR_W-1:0];
            end
        end
    end

    logic [ENT_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [NUM_REGIONS-1:0] mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [15:0]            miss_count_q, miss_count_d;

    logic             req, defer_hit, full, empty;
    logic             accept, direct, push, pop, miss;
    logic [ENT_W-1:0] head;
    logic [IDX_W-1:0] head_idx;
    logic [ADDR_W-1:0] head_off;
    logic [DATA_W-1:0] head_data;

    assign req       = chip_select & write;
    assign defer_hit = hit & DEFER_MASK[hit_idx];
    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    // A pop in the same cycle deliberately does not relieve backpressure.
    assign waitrequest = req & defer_hit & full;
    assign accept    = req & ~waitrequest;
    assign direct    = accept & hit & ~defer_hit;
    assign push      = accept & defer_hit;
    assign miss      = accept & ~hit;
    assign pop       = vblank & ~empty & ~direct;

    assign head = fifo_mem[rd_ptr_q];
    assign {head_idx, head_off, head_data} = head;

    always_comb begin
        mem_we_d     = '0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        level_d      = level_q + LVL_W'(push) - LVL_W'(pop);
        miss_count_d = miss_count_q;
        if (direct) begin
            mem_we_d    = NUM_REGIONS'(1) << hit_idx;
            mem_addr_d  = hit_off;
            mem_wdata_d = writedata;
        end else if (pop) begin
            mem_we_d    = NUM_REGIONS'(1) << head_idx;
            mem_addr_d  = head_off;
            mem_wdata_d = head_data;
        end
        if (miss && miss_count_q != 16'hFFFF)
            miss_count_d = miss_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {hit_idx, hit_off, writedata};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            miss_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fifo_level = level_q;
    assign miss_count = miss_count_q;

endmodule
